// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// Parametrised modulo counter used for game timing and position/score logic
// (paddle step timers, ball-speed dividers, score digits). Counts 0..MODULUS-1
// up or down, either wrapping or saturating at the bounds, with a synchronous
// clear, a clamped synchronous load and an internal prescaler. A registered
// terminal-count pulse lets digits be cascaded (tc of units -> enable of tens).
//
// Parameters
//   WIDTH     bit width of count (>= 1)
//   MODULUS   count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   SATURATE  0 = wrap at the bounds, 1 = hold at the bounds
//   PRESCALE  enabled cycles per count step (>= 1)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   enable      advances the prescaler; the count steps when it expires
//   up          1 = increment, 0 = decrement (sampled on each step)
//   clear       synchronous clear of count and prescaler
//   load        synchronous load of load_value (clamped to MODULUS-1)
//   load_value  value to load
//   count       current count (registered)
//   tick        one-cycle pulse after each count step (registered)
//   tc          one-cycle terminal-count pulse (registered)
//   at_max      count == MODULUS-1
//   at_min      count == 0
// -----------------------------------------------------------------------------
module updown_mod_counter #(
   parameter int WIDTH    = 8,
   parameter int MODULUS  = 10,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int               WP1      = WIDTH + 1;
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WP1-1:0]   MOD_EXT  = WP1'(MODULUS);
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
   localparam logic             SAT_MODE = (SATURATE != 0);

   logic [WIDTH-1:0] count_r;
   logic             tick_r;
   logic             tc_r;
   logic [PW-1:0]    presc_r;

   logic             step_s;
   logic [PW-1:0]    presc_nxt_s;
   logic [WIDTH-1:0] count_nxt_s;
   logic             tc_nxt_s;
   logic [WIDTH-1:0] load_clamped_s;

   // Clamp an out-of-range load value to the top of the count range.
   // The compare is done one bit wider so MODULUS == 2**WIDTH still works.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      if ({1'b0, v} < MOD_EXT) begin
         return v;
      end else begin
         return MAX_VAL;
      end
   endfunction

   // Prescaler: advances on enabled cycles, flags a step when it expires.
   always_comb begin
      step_s      = 1'b0;
      presc_nxt_s = presc_r;
      if (enable) begin
         if (presc_r == PRE_LAST) begin
            presc_nxt_s = '0;
            step_s      = 1'b1;
         end else begin
            presc_nxt_s = presc_r + PW'(1);
         end
      end else begin
         presc_nxt_s = presc_r;
      end
   end

   // Next count and terminal-count flag for a step in the current direction.
   // Bounds use explicit compares so wrap never relies on natural overflow.
   always_comb begin
      count_nxt_s = count_r;
      tc_nxt_s    = 1'b0;
      if (up) begin
         if (count_r == MAX_VAL) begin
            if (SAT_MODE) begin
               count_nxt_s = count_r;
               tc_nxt_s    = 1'b0;
            end else begin
               count_nxt_s = '0;
               tc_nxt_s    = 1'b1;
            end
         end else begin
            count_nxt_s = count_r + WIDTH'(1);
            tc_nxt_s    = SAT_MODE && (count_r == (MAX_VAL - WIDTH'(1)));
         end
      end else begin
         if (count_r == '0) begin
            if (SAT_MODE) begin
               count_nxt_s = count_r;
               tc_nxt_s    = 1'b0;
            end else begin
               count_nxt_s = MAX_VAL;
               tc_nxt_s    = 1'b1;
            end
         end else begin
            count_nxt_s = count_r - WIDTH'(1);
            tc_nxt_s    = SAT_MODE && (count_r == WIDTH'(1));
         end
      end
   end

   // Load value after clamping into range.
   always_comb begin
      load_clamped_s = clamp_load(load_value);
   end

   // State update, priority reset > clear > load > step > hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
         presc_r <= '0;
         tick_r  <= 1'b0;
         tc_r    <= 1'b0;
      end else if (clear) begin
         count_r <= '0;
         presc_r <= '0;
         tick_r  <= 1'b0;
         tc_r    <= 1'b0;
      end else if (load) begin
         count_r <= load_clamped_s;
         presc_r <= '0;
         tick_r  <= 1'b0;
         tc_r    <= 1'b0;
      end else begin
         presc_r <= presc_nxt_s;
         if (step_s) begin
            count_r <= count_nxt_s;
            tick_r  <= 1'b1;
            tc_r    <= tc_nxt_s;
         end else begin
            tick_r  <= 1'b0;
            tc_r    <= 1'b0;
         end
      end
   end

   assign count  = count_r;
   assign tick   = tick_r;
   assign tc     = tc_r;
   assign at_max = (count_r == MAX_VAL);
   assign at_min = (count_r == '0);

endmodule
